// File: rtl/rx_frame_sync.sv
// Receive framer: hunts preamble + SFD, takes the PHR length, then writes the PSDU
// to the outFIFO as LSB-first nibbles, reporting frame status and errors.
module rx_frame_sync #(
    parameter int         PREAMBLE_BITS = 32,
    parameter logic [7:0] SFD           = 8'hA7,
    parameter int         MAX_LEN       = 127,
    parameter int         TIMEOUT       = 64
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inBit,
    input  logic       inBitValid,
    input  logic       inFull,
    input  logic       inClearStatus,
    output logic [3:0] outData,
    output logic       outWriteEnable,
    output logic [6:0] outFrameLen,
    output logic       outFrameStart,
    output logic       outFrameDone,
    output logic       outSyncError,
    output logic       outLenError,
    output logic       outTimeout,
    output logic       outOverflow,
    output logic       outBusy,
    output logic [1:0] outState
);

    localparam int ZC_W  = $clog2(PREAMBLE_BITS + 1);
    localparam int GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [ZC_W-1:0]  PRE_C     = ZC_W'(PREAMBLE_BITS);
    localparam logic [GAP_W-1:0] TIMEOUT_C = GAP_W'(TIMEOUT);
    localparam logic [6:0]       MAX_LEN_C = 7'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_SFD     = 2'd1,
        ST_LEN     = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ZC_W-1:0]   zc_q, zc_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [7:0]        sr_q, sr_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        nib_cnt_q, nib_cnt_d;
    logic [6:0]        frame_len_q, frame_len_d;
    logic [3:0]        data_q, data_d;
    logic              we_q, we_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              sync_err_q, sync_err_d;
    logic              len_err_q, len_err_d;
    logic              tmo_q, tmo_d;
    logic              ovf_q, ovf_d;

    logic [7:0]        sr_shift;
    logic [GAP_W-1:0]  gap_inc;
    logic [7:0]        nib_last;
    logic              ovf_set;

    always_ff @(posedge inClock) begin
        if (!inReset) begin
            state_q     <= ST_HUNT;
            zc_q        <= '0;
            gap_q       <= '0;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            nib_cnt_q   <= '0;
            frame_len_q <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            sync_err_q  <= 1'b0;
            len_err_q   <= 1'b0;
            tmo_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            zc_q        <= zc_d;
            gap_q       <= gap_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            nib_cnt_q   <= nib_cnt_d;
            frame_len_q <= frame_len_d;
            data_q      <= data_d;
            we_q        <= we_d;
            start_q     <= start_d;
            done_q      <= done_d;
            sync_err_q  <= sync_err_d;
            len_err_q   <= len_err_d;
            tmo_q       <= tmo_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        zc_d        = zc_q;
        gap_d       = '0;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        nib_cnt_d   = nib_cnt_q;
        frame_len_d = frame_len_q;
        data_d      = data_q;
        we_d        = 1'b0;
        start_d     = 1'b0;
        done_d      = 1'b0;
        sync_err_d  = 1'b0;
        len_err_d   = 1'b0;
        tmo_d       = 1'b0;
        ovf_set     = 1'b0;
        // Bits arrive LSB first, so each new bit enters at the top.
        sr_shift    = {inBit, sr_q[7:1]};
        gap_inc     = gap_q + 1'b1;
        nib_last    = {frame_len_q, 1'b0} - 8'd1;

        case (state_q)
            ST_HUNT: begin
                if (inBitValid) begin
                    if (inBit) begin
                        zc_d = '0;
                        if (zc_q >= PRE_C) begin
                            state_d   = ST_SFD;
                            sr_d      = 8'h80;
                            bit_cnt_d = 3'd1;
                        end
                    end else if (zc_q != PRE_C) begin
                        zc_d = zc_q + 1'b1;
                    end
                end
            end
            ST_SFD: begin
                if (inBitValid) begin
                    sr_d      = sr_shift;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (sr_shift == SFD) begin
                            state_d = ST_LEN;
                        end else begin
                            state_d    = ST_HUNT;
                            sync_err_d = 1'b1;
                        end
                    end
                end
            end
            ST_LEN: begin
                if (inBitValid) begin
                    sr_d      = sr_shift;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (sr_shift[6:0] == 7'd0 || sr_shift[6:0] > MAX_LEN_C) begin
                            state_d   = ST_HUNT;
                            len_err_d = 1'b1;
                        end else begin
                            state_d     = ST_PAYLOAD;
                            frame_len_d = sr_shift[6:0];
                            start_d     = 1'b1;
                            nib_cnt_d   = '0;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (inBitValid) begin
                    sr_d      = sr_shift;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd3) begin
                        bit_cnt_d = '0;
                        nib_cnt_d = nib_cnt_q + 8'd1;
                        // A full FIFO drops the nibble but still counts it to keep byte alignment.
                        if (inFull) begin
                            ovf_set = 1'b1;
                        end else begin
                            data_d = sr_shift[7:4];
                            we_d   = 1'b1;
                        end
                        if (nib_cnt_q == nib_last) begin
                            state_d = ST_HUNT;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

        if (state_q != ST_HUNT && !inBitValid) begin
            gap_d = gap_inc;
            if (gap_inc == TIMEOUT_C) begin
                state_d = ST_HUNT;
                tmo_d   = 1'b1;
                gap_d   = '0;
            end
        end
        if (state_d == ST_HUNT && state_q != ST_HUNT) begin
            zc_d      = '0;
            bit_cnt_d = '0;
        end

        ovf_d = ovf_set | (ovf_q & ~inClearStatus);
    end

    assign outData        = data_q;
    assign outWriteEnable = we_q;
    assign outFrameLen    = frame_len_q;
    assign outFrameStart  = start_q;
    assign outFrameDone   = done_q;
    assign outSyncError   = sync_err_q;
    assign outLenError    = len_err_q;
    assign outTimeout     = tmo_q;
    assign outOverflow    = ovf_q;
    assign outBusy        = (state_q != ST_HUNT);
    assign outState       = state_q;

endmodule

// File: doc/rx_frame_sync.md
Name: rx_frame_sync

Overview:
- Receive-side framer placed between the CDR (`o_data`/`o_flag` bit stream) and the outFIFO write port. It is the counterpart of the transmit path (inFIFO → msk_modulator).
- Hunts for the 802.15.4 preamble and SFD, then extracts the PHR length byte.
- Deserialises the PSDU into 4-bit nibbles, writes them to the outFIFO with backpressure checking, and reports frame status and errors.

Parameters:
- PREAMBLE_BITS, 32, number of consecutive zero bits required before an SFD is accepted.
- SFD, 8'hA7, start-of-frame delimiter, received LSB first; SFD[0] must be 1.
- MAX_LEN, 127, maximum accepted PSDU length in bytes (1..127).
- TIMEOUT, 64, maximum clock cycles between `inBitValid` pulses while a frame is in progress.

Ports:
- inClock, in, 1, system clock.
- inReset, in, 1, synchronous active-low reset.
- inBit, in, 1, recovered bit from the CDR (`o_data`).
- inBitValid, in, 1, one-cycle strobe marking `inBit` valid (CDR `o_flag`).
- inFull, in, 1, outFIFO full flag.
- inClearStatus, in, 1, clears the sticky `outOverflow` flag.
- outData, out, 4, nibble to the outFIFO; the first received bit is `outData[0]`.
- outWriteEnable, out, 1, one-cycle write strobe to the outFIFO.
- outFrameLen, out, 7, PHR length of the current frame; held until the next PHR.
- outFrameStart, out, 1, one-cycle pulse when a valid PHR has been accepted.
- outFrameDone, out, 1, one-cycle pulse coincident with the final nibble write.
- outSyncError, out, 1, one-cycle pulse on SFD mismatch.
- outLenError, out, 1, one-cycle pulse on an illegal length.
- outTimeout, out, 1, one-cycle pulse on a bit-gap timeout.
- outOverflow, out, 1, sticky flag: a nibble was dropped because `inFull` was high.
- outBusy, out, 1, high in every state except HUNT.

Behaviour:
Clock and reset:
- Single clock. All state changes on the rising edge of `inClock`.
- `inReset`=0 forces HUNT and clears all counters and shift registers. All outputs read 0.
- Reset mid-frame abandons the frame: no partial nibble is written.
- Only edges where `inBitValid`=1 consume a bit.

States:
- HUNT: zero counter `zc` (saturating at PREAMBLE_BITS) increments on a 0 bit and clears on a 1 bit.
  - A 1 bit with `zc` ≥ PREAMBLE_BITS → SFD. That bit is the first SFD bit.
  - A 1 bit with `zc` < PREAMBLE_BITS stays in HUNT.
- SFD: shift in bits LSB first until 8 are held (including the starting 1).
  - Match with SFD → LEN.
  - Mismatch → `outSyncError` pulse, go to HUNT with `zc`=0.
- LEN: capture 8 bits LSB first. len = bits[6:0]; bit 7 is reserved and ignored.
  - len==0 or len>MAX_LEN → `outLenError` pulse, go to HUNT.
  - Otherwise → PAYLOAD, load `outFrameLen`, pulse `outFrameStart` on the cycle after the 8th bit.
- PAYLOAD: 2-bit bit counter and 8-bit nibble counter, total = 2·len nibbles.
  - Each 4th bit completes a nibble.
  - On the cycle after that `inBitValid`: `outData` holds the nibble and `outWriteEnable`=1 for one cycle.
  - Byte order: low nibble first, then high nibble.
  - After the final nibble: `outFrameDone` pulses with the last write, then HUNT.

Backpressure:
- `inFull` is sampled on the edge that completes a nibble.
- If `inFull`=1: the write is suppressed, `outOverflow` is set, and the nibble counter still advances, so frame alignment is kept.
- `outOverflow` clears only on reset or `inClearStatus`=1. If set and clear occur in the same cycle, set wins.

Timeout:
- A gap counter runs in SFD, LEN and PAYLOAD and resets on each `inBitValid`.
- Reaching TIMEOUT → `outTimeout` pulse, go to HUNT. No write for a partial nibble.

Other timing rules:
- `outData` holds its last value when `outWriteEnable`=0.
- All status pulses are registered, with one cycle of latency from the deciding bit.
- The minimum bit spacing supported is 1 cycle (`inBitValid` continuously high).

Test Plan:
- 32×0, SFD A7, PHR 02, payload 5C 3E, `inBitValid` every 4 cycles → `outFrameStart`, `outFrameLen`=2, writes C,5,E,3, `outFrameDone` with the write of 3, `outBusy`→0.
- Only 31×0 then A7 02 AA AA → no `outFrameStart`, no writes, `outBusy` stays 0. Repeat with 40×0 → frame accepted.
- 32×0, SFD B7 → `outSyncError` one pulse, no writes. An immediately following valid frame (32×0, A7, 01, 96) → writes 6,9.
- PHR 00 → `outLenError` pulse. PHR 80 → `outLenError` pulse (bit 7 ignored, len 0). PHR 7F with 127 bytes → 254 writes and `outFrameDone`.
- Len 2 frame with `inFull`=1 only while nibble 2 completes → 3 writes (nibbles 1, 3, 4), `outOverflow`=1 held. `inClearStatus` pulse → 0.
- Stall `inBitValid` for 64 cycles after 6 payload bits → `outTimeout` pulse, 1 write only, HUNT. Separately, assert `inReset` mid-payload → all outputs 0, no further writes.
